// File: rtl/prism_sit_pkg.sv
// Shared definitions for the PRISM SIT row loader: FSM encoding, word selects
// and the row-index width helper.
package prism_sit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        GAP   = 2'd3
    } sit_state_t;

    localparam logic LO_WORD_SEL = 1'b0;
    localparam logic HI_WORD_SEL = 1'b1;

    // A single-row table still needs a 1-bit index counter.
    function automatic int calc_idx_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/prism_sit_row_loader_dec.sv
// Row-index to one-hot latch-enable decoder; the parent registers its output
// so the latch enables stay glitch-free.
module prism_onehot_dec #(
    parameter int DEPTH    = 2,
    parameter int IDX_BITS = 1
) (
    input  logic [IDX_BITS-1:0] idx,
    input  logic                en,
    output logic [DEPTH-1:0]    onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (en && (idx == IDX_BITS'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prism_sit_row_loader.sv
// Assembles debug-bus writes into one SIT row and walks a one-hot latch-enable
// sequence over the latch shift register. Macro PRISM_SIT_LOADER_GAP_EN inserts a quiet cycle between row pulses.
module prism_sit_row_loader
    import prism_sit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_req,
    input  logic [2:0]       address,
    input  logic [31:0]      data_in,
    output logic [WIDTH-1:0] config_data,
    output logic [DEPTH-1:0] latch_en,
    output logic             busy,
    output logic             done,
    output logic             wr_drop
);

    localparam int IDX_BITS = calc_idx_bits(DEPTH);

    sit_state_t          state;
    logic [IDX_BITS-1:0] idx;
    logic [31:0]         low_hold;

    logic                accept_lo;
    logic                accept_hi;
    logic                last_row;
    logic                step_en;
    logic [IDX_BITS-1:0] step_idx;
    logic [DEPTH-1:0]    onehot_next;

    // Upper data bits beyond WIDTH and the low address bits carry no meaning here.
    logic                unused_inputs;
    assign unused_inputs = ^{address[1:0], data_in};

    assign accept_lo = write_req && !busy && (address[2] == LO_WORD_SEL);
    assign accept_hi = write_req && !busy && (address[2] == HI_WORD_SEL);
    assign last_row  = (idx == IDX_BITS'(DEPTH - 1));

    // Which row (if any) opens in the next cycle; feeds the registered decoder.
    always_comb begin
        step_en  = 1'b0;
        step_idx = '0;
        case (state)
            SETUP: begin
                step_en  = 1'b1;
                step_idx = '0;
            end
`ifdef PRISM_SIT_LOADER_GAP_EN
            GAP: begin
                step_en  = !last_row;
                step_idx = idx + IDX_BITS'(1);
            end
`else
            PULSE: begin
                step_en  = !last_row;
                step_idx = idx + IDX_BITS'(1);
            end
`endif
            default: begin
                step_en  = 1'b0;
                step_idx = '0;
            end
        endcase
    end

    prism_onehot_dec #(
        .DEPTH    (DEPTH),
        .IDX_BITS (IDX_BITS)
    ) u_dec (
        .idx    (step_idx),
        .en     (step_en),
        .onehot (onehot_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            low_hold    <= '0;
            config_data <= '0;
            latch_en    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_drop     <= 1'b0;
        end else begin
            done     <= 1'b0;
            wr_drop  <= write_req && busy;
            latch_en <= onehot_next;
            if (accept_lo) begin
                low_hold <= data_in;
            end
            case (state)
                IDLE: begin
                    if (accept_hi) begin
                        config_data <= {data_in[WIDTH-33:0], low_hold};
                        busy        <= 1'b1;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    idx   <= '0;
                    state <= PULSE;
                end
                PULSE: begin
`ifdef PRISM_SIT_LOADER_GAP_EN
                    state <= GAP;
`else
                    // Without inter-row gaps, GAP only serves as the closing quiet cycle.
                    if (last_row) begin
                        state <= GAP;
                    end else begin
                        idx <= idx + IDX_BITS'(1);
                    end
`endif
                end
                GAP: begin
`ifdef PRISM_SIT_LOADER_GAP_EN
                    if (last_row) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + IDX_BITS'(1);
                        state <= PULSE;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
